// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor run controller: FSM states,
// idle register select and instruction field positions.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DUMP_SEL,
    S_DUMP_OUT,
    S_FIN
  } state_t;

  localparam logic [3:0] RID_IDLE = 4'hF;

  localparam int ICODE_MSB = 31;
  localparam int ICODE_LSB = 28;
  localparam int IFUN_MSB  = 27;
  localparam int IFUN_LSB  = 24;
  localparam int RA_MSB    = 23;
  localparam int RA_LSB    = 20;
  localparam int RB_MSB    = 19;
  localparam int RB_LSB    = 16;
  localparam int VALC_MSB  = 15;
  localparam int VALC_LSB  = 0;

  function automatic logic [3:0] icode_of(input logic [31:0] instr);
    return instr[ICODE_MSB:ICODE_LSB];
  endfunction

endpackage

// File: rtl/proc_run_timer.sv
// Run-phase down-counter: loaded before RUN, expires on the last RUN cycle.
// PROC_RUN_CTRL_HALT_EN adds an early halt input and a used-cycle counter.
module proc_run_timer #(
  parameter int CYC_W = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CYC_W-1:0] load_val,
  input  logic             en,
`ifdef PROC_RUN_CTRL_HALT_EN
  input  logic             halt,
  output logic [CYC_W-1:0] run_used,
`endif
  output logic             expire
);

  logic [CYC_W-1:0] r_count;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

`ifdef PROC_RUN_CTRL_HALT_EN
  logic [CYC_W-1:0] r_used;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_used <= '0;
    end else if (load) begin
      r_used <= '0;
    end else if (en) begin
      r_used <= r_used + 1'b1;
    end
  end

  assign run_used = r_used;
  assign expire   = en && ((r_count == CYC_W'(1)) || halt);
`else
  assign expire   = en && (r_count == CYC_W'(1));
`endif

endmodule

// File: rtl/proc_run_ctrl.sv
// Host sequencer for the processor: load program, run for a cycle budget,
// dump r0..r(NREG-1). Optional early halt via PROC_RUN_CTRL_HALT_EN.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int IMEM_DEPTH = 32,
  parameter int DATA_W     = 32,
  parameter int NREG       = 8,
  parameter int CYC_W      = 16
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(IMEM_DEPTH):0] prog_len,
  input  logic [CYC_W-1:0]            run_cycles,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic [31:0]                 addr,
  output logic                        wr,
  output logic [DATA_W-1:0]           wdata,
  output logic                        working,
  output logic [3:0]                  rID,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [2:0]                  cc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [3:0]                  out_idx,
  output logic [2:0]                  cc_snap,
`ifdef PROC_RUN_CTRL_HALT_EN
  input  logic                        halt,
  output logic [CYC_W-1:0]            run_used,
`endif
  output logic                        busy,
  output logic                        done
);

  localparam int         LW       = $clog2(IMEM_DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(IMEM_DEPTH);
  localparam logic [3:0]    LAST_IDX = 4'(NREG - 1);

  state_t           r_state;
  state_t           w_next;
  logic [LW-1:0]    r_len;
  logic [LW-1:0]    r_cnt;
  logic [CYC_W-1:0] r_run_cycles;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_nxt;
  logic [LW-1:0]    w_len_clamp;
  logic             w_in_ready;
  logic             w_hs;
  logic             w_expire;

  assign w_len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign w_in_ready  = (r_state == S_LOAD) && (r_cnt != r_len);
  assign w_hs        = in_valid && w_in_ready;
  assign in_ready    = w_in_ready;
  assign w_idx_nxt   = ((r_state == S_DUMP_OUT) && out_ready && (r_idx != LAST_IDX))
                       ? r_idx + 4'd1 : r_idx;

  proc_run_timer #(.CYC_W(CYC_W)) u_timer (
    .clock    (clock),
    .rst_n    (rst_n),
    .load     (r_state == S_SETTLE),
    .load_val (r_run_cycles),
    .en       (r_state == S_RUN),
`ifdef PROC_RUN_CTRL_HALT_EN
    .halt     (halt),
    .run_used (run_used),
`endif
    .expire   (w_expire)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = (w_len_clamp == '0) ? S_SETTLE : S_LOAD;
      // r_cnt reaches r_len on the last handshake, so this is the last write cycle
      S_LOAD:     if (r_cnt == r_len) w_next = S_SETTLE;
      S_SETTLE:   w_next = S_RUN;
      S_RUN:      if (w_expire) w_next = S_DUMP_SEL;
      S_DUMP_SEL: w_next = S_DUMP_OUT;
      S_DUMP_OUT: if (out_ready) w_next = (r_idx == LAST_IDX) ? S_FIN : S_DUMP_SEL;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_run_cycles <= '0;
      r_idx        <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;
      if (w_hs) r_cnt <= r_cnt + 1'b1;
      if ((r_state == S_IDLE) && start) begin
        r_len        <= w_len_clamp;
        r_run_cycles <= (run_cycles == '0) ? CYC_W'(1) : run_cycles;
        r_cnt        <= '0;
        r_idx        <= '0;
      end
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      wr        <= 1'b0;
      wdata     <= '0;
      working   <= 1'b0;
      rID       <= RID_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      cc_snap   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      wr        <= w_hs;
      addr      <= w_hs ? 32'(r_cnt) : 32'd0;
      wdata     <= w_hs ? in_data : '0;
      working   <= (w_next == S_RUN);
      busy      <= (w_next != S_IDLE);
      done      <= (w_next == S_FIN);
      out_valid <= (w_next == S_DUMP_OUT);
      rID       <= ((w_next == S_DUMP_SEL) || (w_next == S_DUMP_OUT)) ? w_idx_nxt : RID_IDLE;
      if ((r_state == S_RUN) && w_expire) cc_snap <= cc;
      if (r_state == S_DUMP_SEL) begin
        out_data <= rdata;
        out_idx  <= r_idx;
      end
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed self-checking bench for proc_run_ctrl; covers halt/run_used
// when PROC_RUN_CTRL_HALT_EN is defined.
module tb_proc_run_ctrl;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  prog_len;
  logic [15:0] run_cycles;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wdata;
  logic        working;
  logic [3:0]  rID;
  logic [31:0] rdata;
  logic [2:0]  cc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic [2:0]  cc_snap;
  logic        busy;
  logic        done;
`ifdef PROC_RUN_CTRL_HALT_EN
  logic        halt;
  logic [15:0] run_used;
  int          haltAt = 0;
`endif

  int          checkCount = 0;
  int          errCount   = 0;
  int          cycNum     = 0;
  int          lastWrCyc  = 0;
  int          startEdge  = 0;
  logic [31:0] progWords [40];
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  logic [31:0] dumpDataQ[$];
  logic [3:0]  dumpIdxQ[$];
  logic [3:0]  dumpRidQ[$];

  proc_run_ctrl dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .prog_len   (prog_len),
    .run_cycles (run_cycles),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .addr       (addr),
    .wr         (wr),
    .wdata      (wdata),
    .working    (working),
    .rID        (rID),
    .rdata      (rdata),
    .cc         (cc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .cc_snap    (cc_snap),
`ifdef PROC_RUN_CTRL_HALT_EN
    .halt       (halt),
    .run_used   (run_used),
`endif
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Processor register file model: a fixed value per register index
  function automatic logic [31:0] regVal(input logic [3:0] idx);
    return 32'hA5A5_0000 + 32'(idx) * 32'h0000_0111;
  endfunction

  assign rdata = (rID < 4'd8) ? regVal(rID) : 32'hDEAD_BEEF;

  always @(posedge clock) cycNum <= cycNum + 1;

  always @(negedge clock) begin
    if (wr) begin
      wrAddrQ.push_back(addr);
      wrDataQ.push_back(wdata);
      lastWrCyc = cycNum;
    end
  end

  always @(posedge clock) begin
    if (rst_n && out_valid && out_ready) begin
      dumpIdxQ.push_back(out_idx);
      dumpDataQ.push_back(out_data);
      dumpRidQ.push_back(rID);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Pulse start, then stream words (optionally toggling in_valid) until all are accepted
  task automatic applyStimulus(input int len, input int cycles, input bit stall);
    int expLen;
    int sent;
    int guard;
    bit phase;
    bit hs;
    expLen = (len > 32) ? 32 : len;
    wrAddrQ.delete();
    wrDataQ.delete();
    dumpIdxQ.delete();
    dumpDataQ.delete();
    dumpRidQ.delete();
    @(posedge clock); #1;
    start      = 1'b1;
    prog_len   = 6'(len);
    run_cycles = 16'(cycles);
    startEdge  = cycNum + 1;
    @(posedge clock); #1;
    start      = 1'b0;
    prog_len   = 6'd7;
    run_cycles = 16'd2;
    if (expLen > 0) checkOutput("inReadyRise", 32'(in_ready), 32'd1);
    sent  = 0;
    guard = 0;
    phase = 1'b0;
    while (sent < expLen && guard < 300) begin
      in_valid = stall ? !phase : 1'b1;
      in_data  = progWords[sent];
      hs       = in_valid && in_ready;
      @(posedge clock); #1;
      if (hs) sent++;
      phase = !phase;
      guard++;
    end
    checkOutput("wordsAccepted", sent, expLen);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    checkOutput("inReadyDrop", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input int expLen, input int expWork, input bit bp,
                          input bit pulseStart, input bit chkLat);
    int runSeen;
    int riseCyc;
    bit gotDone;
    bit bpDone;
    runSeen = 0;
    riseCyc = 0;
    gotDone = 1'b0;
    bpDone  = 1'b0;
    cc      = 3'd0;
    for (int g = 0; g < 400 && !gotDone; g++) begin
      @(negedge clock);
      start = 1'b0;
`ifdef PROC_RUN_CTRL_HALT_EN
      halt = 1'b0;
`endif
      if (working) begin
        runSeen++;
        if (runSeen == 1) begin
          riseCyc = cycNum;
          checkOutput("busyRun", 32'(busy), 32'd1);
          checkOutput("ridRun", 32'(rID), 32'hF);
        end
        cc = 3'(runSeen);
        if (pulseStart && runSeen == 2) start = 1'b1;
`ifdef PROC_RUN_CTRL_HALT_EN
        if (haltAt != 0 && runSeen == haltAt) halt = 1'b1;
`endif
      end
      if (bp && !bpDone && out_valid && out_idx == 4'd3) begin
        bpDone    = 1'b1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clock);
          checkOutput("bpData", out_data, regVal(4'd3));
          checkOutput("bpIdx", 32'(out_idx), 32'd3);
          checkOutput("bpRid", 32'(rID), 32'd3);
          checkOutput("bpValid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
      end
      if (done) gotDone = 1'b1;
    end
    checkOutput("doneSeen", 32'(gotDone), 32'd1);
    checkOutput("runCycles", runSeen, expWork);
    checkOutput("ccSnap", 32'(cc_snap), 32'(expWork[2:0]));
    checkOutput("wrCount", wrAddrQ.size(), expLen);
    for (int i = 0; i < wrAddrQ.size() && i < expLen; i++) begin
      checkOutput("wrAddr", wrAddrQ[i], i);
      checkOutput("wrData", wrDataQ[i], progWords[i]);
    end
    if (expLen > 0) checkOutput("wrGap", riseCyc - lastWrCyc, 2);
    // working is high in cycle start+len+3, which begins at edge start+len+2
    if (chkLat) checkOutput("startLatency", riseCyc - startEdge, expLen + 2);
    checkOutput("dumpCount", dumpIdxQ.size(), 8);
    for (int i = 0; i < dumpIdxQ.size() && i < 8; i++) begin
      checkOutput("dumpIdx", 32'(dumpIdxQ[i]), i);
      checkOutput("dumpData", dumpDataQ[i], regVal(4'(i)));
      checkOutput("dumpRid", 32'(dumpRidQ[i]), i);
    end
    @(negedge clock);
    checkOutput("donePulse", 32'(done), 32'd0);
    checkOutput("ridIdle", 32'(rID), 32'hF);
    checkOutput("busyIdle", 32'(busy), 32'd0);
    checkOutput("outValidIdle", 32'(out_valid), 32'd0);
    if (pulseStart) begin
      repeat (2) @(negedge clock);
      checkOutput("noRestart", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    bit seen;
    rst_n      = 1'b0;
    start      = 1'b0;
    prog_len   = '0;
    run_cycles = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    cc         = '0;
    out_ready  = 1'b1;
`ifdef PROC_RUN_CTRL_HALT_EN
    halt       = 1'b0;
`endif
    progWords[0] = 32'h10F0_0001;
    progWords[1] = 32'h10F1_0002;
    progWords[2] = 32'h7000_000A;
    for (int i = 3; i < 40; i++) progWords[i] = 32'h30F0_0000 | 32'(i);

    #12;
    checkOutput("rstAddr", addr, 32'd0);
    checkOutput("rstWr", 32'(wr), 32'd0);
    checkOutput("rstWdata", wdata, 32'd0);
    checkOutput("rstWorking", 32'(working), 32'd0);
    checkOutput("rstRid", 32'(rID), 32'hF);
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstOutData", out_data, 32'd0);
    checkOutput("rstOutIdx", 32'(out_idx), 32'd0);
    checkOutput("rstCcSnap", 32'(cc_snap), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    $display("[TB] basic session");
    applyStimulus(3, 5, 1'b0);
    waitDone(3, 5, 1'b0, 1'b0, 1'b1);
`ifdef PROC_RUN_CTRL_HALT_EN
    checkOutput("runUsedFull", 32'(run_used), 32'd5);
`endif

    $display("[TB] input stalls");
    applyStimulus(4, 3, 1'b1);
    waitDone(4, 3, 1'b0, 1'b0, 1'b0);

    $display("[TB] length clamp");
    applyStimulus(40, 2, 1'b0);
    waitDone(32, 2, 1'b0, 1'b0, 1'b1);

    $display("[TB] output backpressure, run_cycles 0");
    applyStimulus(2, 0, 1'b0);
    waitDone(2, 1, 1'b1, 1'b0, 1'b1);

    $display("[TB] start while busy");
    applyStimulus(2, 4, 1'b0);
    waitDone(2, 4, 1'b0, 1'b1, 1'b1);

    $display("[TB] reset mid-run");
    applyStimulus(2, 10, 1'b0);
    seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(negedge clock);
      if (working) seen = 1'b1;
    end
    checkOutput("resetRunReached", 32'(seen), 32'd1);
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstWorking", 32'(working), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstRid", 32'(rID), 32'hF);
    checkOutput("midRstWr", 32'(wr), 32'd0);
    checkOutput("midRstInReady", 32'(in_ready), 32'd0);
    checkOutput("midRstCcSnap", 32'(cc_snap), 32'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    applyStimulus(3, 5, 1'b0);
    waitDone(3, 5, 1'b0, 1'b0, 1'b1);

`ifdef PROC_RUN_CTRL_HALT_EN
    $display("[TB] halt during run");
    haltAt = 3;
    applyStimulus(1, 100, 1'b0);
    waitDone(1, 3, 1'b0, 1'b0, 1'b1);
    checkOutput("runUsedHalt", 32'(run_used), 32'd3);
    haltAt = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
